// File: rtl/enum_name_pkg.sv
// Label table and shared types for the ASCII-name-to-my_t decoder.
package enum_name_pkg;

  localparam int NUM_LABELS = 2;
  localparam int NAME_BYTES = 8;

  typedef enum logic [31:0] {
    E01    = 32'h0000_0001,
    ELARGE = 32'h0000_f00d
  } my_t;

  localparam logic [NUM_LABELS-1:0][31:0] LABEL_VALUE = {32'(ELARGE), 32'(E01)};

  // Names are right-justified: the last character sits in the low byte.
  localparam logic [NUM_LABELS-1:0][NAME_BYTES*8-1:0] LABEL_NAME = {
    64'h0000_454c_4152_4745,
    64'h0000_0000_0045_3031
  };

  localparam logic [NUM_LABELS-1:0][3:0] LABEL_LEN = {4'd6, 4'd3};

  typedef logic [0:0] dec_state_t;
  localparam dec_state_t RECV = 1'b0;
  localparam dec_state_t RESP = 1'b1;

  // Character at position pos of a right-justified name of length len (pos < len).
  function automatic logic [7:0] label_char(input logic [NAME_BYTES*8-1:0] name,
                                            input logic [3:0] len,
                                            input logic [3:0] pos);
    logic [2:0] slot;
    slot = 3'(len - pos - 4'd1);
    return name[{slot, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/enum_name_decoder.sv
// Streams an ASCII name byte by byte and returns the matching my_t value or "unknown".
// Optional feature macro: ENUM_NAME_DECODER_NEXT_EN adds out_next/out_prev.
module enum_name_decoder
  import enum_name_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int VAL_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [VAL_W-1:0] out_value,
`ifdef ENUM_NAME_DECODER_NEXT_EN
  output logic [VAL_W-1:0] out_next,
  output logic [VAL_W-1:0] out_prev,
`endif
  output logic             out_known,
  output logic             out_index
);

  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int IW = (NUM_LABELS > 1) ? $clog2(NUM_LABELS) : 1;

  dec_state_t              state_r;
  logic [NUM_LABELS-1:0]   cand_r;
  logic [LW-1:0]           len_r;
  logic                    overflow_r;
  logic                    out_valid_r;
  logic [VAL_W-1:0]        out_value_r;
  logic                    out_known_r;
  logic [IW-1:0]           out_index_r;

  logic [NUM_LABELS-1:0]   hit_s;
  logic [NUM_LABELS-1:0]   full_s;
  logic [NUM_LABELS-1:0]   match_s;
  logic                    accept_s;
  logic                    ovf_next_s;
  logic [VAL_W-1:0]        val_s;
  logic [IW-1:0]           idx_s;

  assign in_ready   = (state_r == RECV);
  assign accept_s   = in_valid && in_ready;
  assign ovf_next_s = overflow_r | (len_r == LW'(MAX_LEN));

  for (genvar g = 0; g < NUM_LABELS; g++) begin : g_cmp
    assign hit_s[g]  = (int'(len_r) < int'(LABEL_LEN[g])) &&
                       (in_data == label_char(LABEL_NAME[g], LABEL_LEN[g], 4'(len_r)));
    assign full_s[g] = ((int'(len_r) + 1) == int'(LABEL_LEN[g]));
  end

  assign match_s = cand_r & hit_s & full_s & {NUM_LABELS{!ovf_next_s}};

`ifdef ENUM_NAME_DECODER_NEXT_EN
  logic [VAL_W-1:0] next_s;
  logic [VAL_W-1:0] prev_s;
  logic [VAL_W-1:0] out_next_r;
  logic [VAL_W-1:0] out_prev_r;
  assign out_next = out_next_r;
  assign out_prev = out_prev_r;
`endif

  // Result lookup for the final beat; labels are unique so at most one match bit is set.
  always_comb begin
    val_s = '0;
    idx_s = '0;
`ifdef ENUM_NAME_DECODER_NEXT_EN
    next_s = '0;
    prev_s = '0;
`endif
    for (int i = 0; i < NUM_LABELS; i++) begin
      val_s = val_s | ({VAL_W{match_s[i]}} & VAL_W'(LABEL_VALUE[IW'(i)]));
      idx_s = idx_s | ({IW{match_s[i]}} & IW'(i));
`ifdef ENUM_NAME_DECODER_NEXT_EN
      next_s = next_s | ({VAL_W{match_s[i]}} &
                         VAL_W'(LABEL_VALUE[IW'((i + 1) % NUM_LABELS)]));
      prev_s = prev_s | ({VAL_W{match_s[i]}} &
                         VAL_W'(LABEL_VALUE[IW'((i + NUM_LABELS - 1) % NUM_LABELS)]));
`endif
    end
  end

  // Receive/response FSM with candidate tracking and registered result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= RECV;
      cand_r      <= '1;
      len_r       <= '0;
      overflow_r  <= 1'b0;
      out_valid_r <= 1'b0;
      out_value_r <= '0;
      out_known_r <= 1'b0;
      out_index_r <= '0;
`ifdef ENUM_NAME_DECODER_NEXT_EN
      out_next_r  <= '0;
      out_prev_r  <= '0;
`endif
    end else begin
      case (state_r)
        RECV: begin
          if (accept_s && in_last) begin
            state_r     <= RESP;
            out_valid_r <= 1'b1;
            out_value_r <= val_s;
            out_known_r <= |match_s;
            out_index_r <= idx_s;
`ifdef ENUM_NAME_DECODER_NEXT_EN
            out_next_r  <= next_s;
            out_prev_r  <= prev_s;
`endif
            cand_r      <= '1;
            len_r       <= '0;
            overflow_r  <= 1'b0;
          end else if (accept_s) begin
            cand_r     <= cand_r & hit_s;
            overflow_r <= ovf_next_s;
            if (len_r == LW'(MAX_LEN)) begin
              len_r <= len_r;
            end else begin
              len_r <= len_r + LW'(1);
            end
          end else begin
            cand_r <= cand_r;
          end
        end
        RESP: begin
          if (out_ready) begin
            state_r     <= RECV;
            out_valid_r <= 1'b0;
          end else begin
            state_r <= RESP;
          end
        end
        default: begin
          state_r     <= RECV;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid = out_valid_r;
  assign out_value = out_value_r;
  assign out_known = out_known_r;
  assign out_index = out_index_r[0];

endmodule

// File: tb/tb_enum_name_decoder.sv
// Self-checking bench for enum_name_decoder: vector table, hand sequences, random names.
module tb_enum_name_decoder;

  localparam int MAX_LEN = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_value;
  logic        out_known;
  logic        out_index;
`ifdef ENUM_NAME_DECODER_NEXT_EN
  logic [31:0] out_next;
  logic [31:0] out_prev;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  enum_name_decoder #(.MAX_LEN(MAX_LEN), .VAL_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_value (out_value),
`ifdef ENUM_NAME_DECODER_NEXT_EN
    .out_next  (out_next),
    .out_prev  (out_prev),
`endif
    .out_known (out_known),
    .out_index (out_index)
  );

  typedef struct {
    string       name;
    int          stall;
    logic        known;
    logic [31:0] value;
    logic        idx;
  } vec_t;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: exact byte-for-byte comparison against the label names.
  function automatic void ref_decode(input logic [7:0] q[$], output logic known,
                                     output logic [31:0] val, output logic idx);
    string       lab [2];
    logic [31:0] v   [2];
    logic        same;
    lab[0] = "E01";    v[0] = 32'h1;
    lab[1] = "ELARGE"; v[1] = 32'hf00d;
    known = 1'b0; val = 32'h0; idx = 1'b0;
    if (q.size() <= MAX_LEN) begin
      for (int i = 0; i < 2; i++) begin
        same = (q.size() == lab[i].len());
        for (int k = 0; k < q.size() && same; k++)
          if (q[k] != lab[i][k]) same = 1'b0;
        if (same) begin
          known = 1'b1; val = v[i]; idx = (i == 1);
        end
      end
    end
  endfunction

  task automatic send_name(input logic [7:0] q[$], input int stall, input logic exp_known,
                           input logic [31:0] exp_val, input logic exp_idx, input string tag);
    int guard;
    out_ready = 1'b0;
    for (int k = 0; k < q.size(); k++) begin
      in_valid = 1'b1;
      in_data  = q[k];
      in_last  = (k == q.size() - 1);
      guard = 0;
      while (!in_ready && guard < 20) begin
        tick();
        guard++;
      end
      if (guard >= 20) check({tag, " ready_timeout"}, 32'(in_ready), 32'h1);
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 8'h00;
    check({tag, " latency_valid"}, 32'(out_valid), 32'h1);
    check({tag, " value"}, out_value, exp_val);
    check({tag, " known"}, 32'(out_known), 32'(exp_known));
    check({tag, " index"}, 32'(out_index), 32'(exp_idx));
`ifdef ENUM_NAME_DECODER_NEXT_EN
    check({tag, " next"}, out_next,
          exp_known ? ((exp_val == 32'h1) ? 32'hf00d : 32'h1) : 32'h0);
    check({tag, " prev"}, out_prev,
          exp_known ? ((exp_val == 32'h1) ? 32'hf00d : 32'h1) : 32'h0);
`endif
    for (int s = 0; s < stall; s++) begin
      tick();
      check({tag, " hold_valid"}, 32'(out_valid), 32'h1);
      check({tag, " hold_ready"}, 32'(in_ready), 32'h0);
      check({tag, " hold_value"}, out_value, exp_val);
      check({tag, " hold_index"}, 32'(out_index), 32'(exp_idx));
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, " pop_valid"}, 32'(out_valid), 32'h0);
    check({tag, " pop_ready"}, 32'(in_ready), 32'h1);
  endtask

  initial begin
    vec_t        vecs [10];
    logic [7:0]  q [$];
    logic [7:0]  bq [$];
    logic        bl [$];
    logic [31:0] results [$];
    string       alpha;
    string       lbl;
    logic        ek;
    logic [31:0] ev;
    logic        ei;
    logic        rdy;
    int          ptr;
    int          bubbles;
    int          n;

    vecs[0] = '{"E01",       0, 1'b1, 32'h1,    1'b0};
    vecs[1] = '{"ELARGE",    5, 1'b1, 32'hf00d, 1'b1};
    vecs[2] = '{"E0",        1, 1'b0, 32'h0,    1'b0};
    vecs[3] = '{"E011",      0, 1'b0, 32'h0,    1'b0};
    vecs[4] = '{"e01",       2, 1'b0, 32'h0,    1'b0};
    vecs[5] = '{"ELARGEXYZ", 0, 1'b0, 32'h0,    1'b0};
    vecs[6] = '{"ELARG",     0, 1'b0, 32'h0,    1'b0};
    vecs[7] = '{"E",         0, 1'b0, 32'h0,    1'b0};
    vecs[8] = '{"ELARGEEE",  0, 1'b0, 32'h0,    1'b0};
    vecs[9] = '{"EL01",      0, 1'b0, 32'h0,    1'b0};

    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0; out_ready = 1'b0;
    #12;
    check("reset in_ready", 32'(in_ready), 32'h1);
    check("reset out_valid", 32'(out_valid), 32'h0);
    check("reset out_value", out_value, 32'h0);
    check("reset out_known", 32'(out_known), 32'h0);
    check("reset out_index", 32'(out_index), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    for (int v = 0; v < 10; v++) begin
      q = {};
      for (int k = 0; k < vecs[v].name.len(); k++) q.push_back(vecs[v].name[k]);
      send_name(q, vecs[v].stall, vecs[v].known, vecs[v].value, vecs[v].idx, vecs[v].name);
    end

    // NUL is an ordinary non-matching character.
    q = {8'h45, 8'h00, 8'h31};
    send_name(q, 0, 1'b0, 32'h0, 1'b0, "nul");

    // Reset in the middle of a name, then a clean name.
    foreach (q[k]) q[k] = 8'h00;
    lbl = "ELA";
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_data = lbl[k]; in_last = 1'b0;
      tick();
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    check("midname_rst in_ready", 32'(in_ready), 32'h1);
    check("midname_rst out_valid", 32'(out_valid), 32'h0);
    rst_n = 1'b1;
    tick();
    q = {8'h45, 8'h30, 8'h31};
    send_name(q, 0, 1'b1, 32'h1, 1'b0, "after_rst E01");

    // Reset while a result is pending.
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_data = q[k]; in_last = (k == 2);
      tick();
    end
    in_valid = 1'b0; in_last = 1'b0;
    check("resp_rst pre_valid", 32'(out_valid), 32'h1);
    rst_n = 1'b0;
    #2;
    check("resp_rst out_valid", 32'(out_valid), 32'h0);
    check("resp_rst out_value", out_value, 32'h0);
    check("resp_rst in_ready", 32'(in_ready), 32'h1);
    rst_n = 1'b1;
    tick();

    // Back-to-back names with in_valid always high.
    lbl = "E01";
    for (int k = 0; k < 3; k++) begin bq.push_back(lbl[k]); bl.push_back(k == 2); end
    lbl = "ELARGE";
    for (int k = 0; k < 6; k++) begin bq.push_back(lbl[k]); bl.push_back(k == 5); end
    out_ready = 1'b1;
    ptr = 0; bubbles = 0;
    for (int cyc = 0; cyc < 40 && !(ptr == bq.size() && results.size() == 2); cyc++) begin
      if (out_valid) results.push_back(out_value);
      if (!in_ready) bubbles++;
      if (ptr < bq.size()) begin
        in_valid = 1'b1; in_data = bq[ptr]; in_last = bl[ptr];
      end else begin
        in_valid = 1'b0; in_last = 1'b0;
      end
      rdy = in_ready;
      tick();
      if (rdy && ptr < bq.size()) ptr++;
    end
    in_valid = 1'b0; in_last = 1'b0;
    tick();
    out_ready = 1'b0;
    check("b2b result_count", 32'(results.size()), 32'h2);
    if (results.size() >= 2) begin
      check("b2b first", results[0], 32'h1);
      check("b2b second", results[1], 32'hf00d);
    end
    check("b2b bubbles", 32'(bubbles), 32'h2);
    check("b2b idle_ready", 32'(in_ready), 32'h1);

    // Random names scored against the reference.
    alpha = "E01LARGEXe";
    for (int t = 0; t < 40; t++) begin
      q = {};
      case ($urandom_range(0, 3))
        0: lbl = "E01";
        1: lbl = "ELARGE";
        default: lbl = "";
      endcase
      if (lbl.len() > 0) begin
        for (int k = 0; k < lbl.len(); k++) q.push_back(lbl[k]);
      end else begin
        n = $urandom_range(1, 10);
        for (int k = 0; k < n; k++) begin
          int r;
          r = $urandom_range(0, 10);
          q.push_back((r == 10) ? 8'h00 : alpha[r]);
        end
      end
      ref_decode(q, ek, ev, ei);
      send_name(q, $urandom_range(0, 3), ek, ev, ei, $sformatf("rand%0d", t));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
